// File: rtl/ooo_pkg.sv
// Shared core types for the front end: fetch width, datapath width,
// the fetch-queue entry record and a small lane-count helper.
package ooo_pkg;

    localparam int FETCH_WIDTH = 2;
    localparam int XLEN        = 32;
    localparam int FQ_DEPTH    = 8;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fq_entry_t;

    // Number of set bits in a two-lane valid vector.
    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {v[1] & v[0], v[1] ^ v[0]};
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for the fetch queue.
// Ports: if_* (fetch lanes in), fq_* (decode lanes out), decode_ready, fq_count.
interface fetch_queue_if
    import ooo_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CW   = 4
);
    logic [FETCH_WIDTH-1:0]           if_valid;
    logic [FETCH_WIDTH-1:0][XLEN-1:0] if_instr;
    logic [FETCH_WIDTH-1:0][XLEN-1:0] if_pc;
    logic                             fq_ready;
    logic                             decode_ready;
    logic [FETCH_WIDTH-1:0]           fq_valid;
    logic [FETCH_WIDTH-1:0][XLEN-1:0] fq_instr;
    logic [FETCH_WIDTH-1:0][XLEN-1:0] fq_pc;
    logic [CW-1:0]                    fq_count;

    // Queue side.
    modport slave (
        input  if_valid, if_instr, if_pc, decode_ready,
        output fq_ready, fq_valid, fq_instr, fq_pc, fq_count
    );

    // Fetch/decode environment side.
    modport master (
        output if_valid, if_instr, if_pc, decode_ready,
        input  fq_ready, fq_valid, fq_instr, fq_pc, fq_count
    );
endinterface

// File: rtl/fetch_queue.sv
// Two-wide in-order instruction buffer between fetch and decode.
// Ports: clk, reset (async, active-low), flush, bus (fetch_queue_if.slave).
// Optional FQ_BYPASS_EN: forwards input to output when empty and decode ready.
module fetch_queue
    import ooo_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int XLEN  = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    fetch_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] mem_instr [DEPTH];
    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [AW-1:0]   head_p1;
    logic [AW-1:0]   tail_p1;
    logic [CW-1:0]   count;

    logic            ready;
    logic [1:0]      q_valid;
    logic [1:0]      in_n;
    logic [1:0]      enq_n;
    logic [1:0]      deq_n;
    logic            bypass;
    logic [XLEN-1:0] c_instr0;
    logic [XLEN-1:0] c_pc0;

    // Room for a full pair, judged on the registered count only.
    assign ready   = count <= CW'(DEPTH - 2);
    assign q_valid = {count >= CW'(2), count != '0};
    assign head_p1 = head + AW'(1);
    assign tail_p1 = tail + AW'(1);
    assign in_n    = popcount2(bus.if_valid);

`ifdef FQ_BYPASS_EN
    assign bypass = (count == '0) && bus.decode_ready && !flush;
`else
    assign bypass = 1'b0;
`endif

    // Lane compaction: a lone lane 1 lands in slot 0.
    assign c_instr0 = bus.if_valid[0] ? bus.if_instr[0] : bus.if_instr[1];
    assign c_pc0    = bus.if_valid[0] ? bus.if_pc[0]    : bus.if_pc[1];

    assign enq_n = (ready && !flush && !bypass) ? in_n : 2'd0;
    assign deq_n = (bus.decode_ready && !flush) ? popcount2(q_valid) : 2'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_n != 2'd0) begin
                mem_instr[tail] <= c_instr0;
                mem_pc[tail]    <= c_pc0;
            end
            if (enq_n == 2'd2) begin
                mem_instr[tail_p1] <= bus.if_instr[1];
                mem_pc[tail_p1]    <= bus.if_pc[1];
            end
            tail  <= tail + AW'(enq_n);
            head  <= head + AW'(deq_n);
            count <= count + CW'(enq_n) - CW'(deq_n);
        end
    end

    logic [1:0]      o_valid;
    logic [XLEN-1:0] o_instr0;
    logic [XLEN-1:0] o_instr1;
    logic [XLEN-1:0] o_pc0;
    logic [XLEN-1:0] o_pc1;

    always_comb begin
        o_valid  = q_valid;
        o_instr0 = q_valid[0] ? mem_instr[head]    : '0;
        o_pc0    = q_valid[0] ? mem_pc[head]       : '0;
        o_instr1 = q_valid[1] ? mem_instr[head_p1] : '0;
        o_pc1    = q_valid[1] ? mem_pc[head_p1]    : '0;
`ifdef FQ_BYPASS_EN
        if (bypass) begin
            o_valid  = {in_n == 2'd2, in_n != 2'd0};
            o_instr0 = (in_n != 2'd0) ? c_instr0 : '0;
            o_pc0    = (in_n != 2'd0) ? c_pc0    : '0;
            o_instr1 = (in_n == 2'd2) ? bus.if_instr[1] : '0;
            o_pc1    = (in_n == 2'd2) ? bus.if_pc[1]    : '0;
        end
`endif
    end

    assign bus.fq_ready = ready;
    assign bus.fq_valid = o_valid;
    assign bus.fq_instr = {o_instr1, o_instr0};
    assign bus.fq_pc    = {o_pc1, o_pc0};
    assign bus.fq_count = count;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Two-wide instruction buffer between the fetch stage and decode in `ooo_core_top`. It accepts up to two fetched instruction/PC pairs per cycle from `if_*` and presents up to two in program order to decode. It holds them while decode stalls, and discards everything on a pipeline flush. It decouples I-fetch latency from decode/rename backpressure and removes combinational stall paths from decode back to the PC logic.

## Interface
Parameters:
- `DEPTH`, 8, number of entries; power of two, ≥4
- `XLEN`, 32, instruction and PC width

Ports:
- `clk`  in  1  core clock
- `reset`  in  1  asynchronous, active-low reset
- `flush`  in  1  pipeline flush (redirect or mispredict); drops all contents
- `if_valid`  in  2  per-lane fetch valid
- `if_instr`  in  2×XLEN  fetched instructions
- `if_pc`  in  2×XLEN  PCs of fetched instructions
- `fq_ready`  out  1  queue can accept two entries this cycle
- `decode_ready`  in  1  decode consumes all valid output lanes this cycle
- `fq_valid`  out  2  per-lane output valid; `2'b10` never occurs
- `fq_instr`  out  2×XLEN  instructions to decode; lane 0 is older
- `fq_pc`  out  2×XLEN  matching PCs
- `fq_count`  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Storage is a circular buffer of `DEPTH` entries {instr, pc}, with registered `head` and `tail` pointers (log2 DEPTH bits, natural wrap) and a registered `count`.
- **Enqueue:**
  - Occurs when `fq_ready && !flush`. Valid input lanes are compacted in order.
  - `if_valid=2'b11` writes lane0 at `tail` and lane1 at `tail+1`. `tail += 2`.
  - `2'b01` writes lane0 only. `2'b10` writes lane1 at `tail`. Each adds 1 to `tail`.
- **Readiness:** `fq_ready = (DEPTH - count) >= 2`, computed from the registered count only. Same-cycle dequeue is not credited. Input offered while `fq_ready=0` is ignored, and fetch must hold it.
- **Output:**
  - `fq_valid[0] = count≥1`, `fq_valid[1] = count≥2`.
  - Lane0 shows entry `head`, lane1 shows `head+1`.
  - Instr/PC of an invalid lane is driven to 0.
- **Dequeue:** when `decode_ready && !flush`, `head += popcount(fq_valid)`.
- **Count update:** `count_next = count + enq_n - deq_n`. Simultaneous enqueue and dequeue in any combination (including count=DEPTH-2 with both) is legal.
- **Flush:**
  - Next cycle `head = tail = count = 0`, `fq_valid=0`, `fq_ready=1`.
  - Same-cycle enqueue and dequeue are both suppressed.
  - Flush has priority over everything except `reset`.
- **Reset:**
  - Pointers and count are 0 and entries are cleared to 0.
  - Outputs after reset: `fq_valid=2'b00`, `fq_instr=0`, `fq_pc=0`, `fq_count=0`, `fq_ready=1`.
  - Reset asserted mid-operation discards contents immediately (asynchronous).

## Timing
- Baseline latency: an entry enqueued at edge N is visible on `fq_*` in cycle N+1.
- `fq_ready`, `fq_valid` and `fq_count` are functions of registered state only. There is no combinational path from `if_valid` or `decode_ready` to `fq_ready`.
- The `flush` to empty-output delay is one edge.
- Sustained throughput is 2 instr/cycle with `decode_ready` held high and fetch delivering `2'b11`.

## Configuration
- `FQ_BYPASS_EN`
  - **Defined:**
    - When `count==0`, `decode_ready=1` and `flush=0`, input lanes are forwarded combinationally to `fq_*` in the same cycle (zero latency). Compacted the same way, so `if_valid=2'b10` appears as `fq_valid=2'b01`.
    - Forwarded lanes are not written to storage.
    - If `decode_ready=0`, the entries are enqueued normally.
  - **Undefined:** no input-to-output combinational path. Latency is always ≥1 cycle.

## Structure
- Shared package `ooo_pkg` holds:
  - `FETCH_WIDTH=2`
  - `XLEN`
  - `typedef struct packed {logic [XLEN-1:0] instr; logic [XLEN-1:0] pc;} fq_entry_t`
  - default `FQ_DEPTH=8`
- No sub-module: a single module containing the entry array, pointer logic and output mux.

## Test plan
- **Reset:** assert `reset=0` mid-fill with count=5, then release. Expect `fq_valid=00`, `fq_count=0`, `fq_ready=1`, and all outputs 0.
- **Ordering:**
  - Stimulus: `decode_ready=0`, 3 cycles of `2'b11` with PCs 0x00–0x14, then `decode_ready=1`.
  - Expect `fq_count=6` while stalled.
  - Outputs in consecutive cycles: (0x00,0x04), (0x08,0x0C), (0x10,0x14). Then count=0.
- **Full and wrap:**
  - Fill to 8 with `decode_ready=0`. Expect `fq_ready=0`.
  - Input offered while not ready is dropped.
  - Drain 2, then refill 2 across the index-7→0 boundary. PCs stay in order.
- **Partial lanes:**
  - `if_valid=2'b10` (PC 0x24) then `2'b01` (PC 0x28).
  - Expect a single entry each, output (0x24,0x28) with `fq_valid=11`.
- **Flush:**
  - count=4 with `flush=1` and simultaneous `if_valid=11` and `decode_ready=1`.
  - Next cycle: `fq_count=0`, `fq_valid=00`. Nothing from that cycle's input appears.
- **Bypass (`FQ_BYPASS_EN`):**
  - Queue empty, `decode_ready=1`, input PCs 0x40/0x44. Expect `fq_valid=11` with 0x40/0x44 in the same cycle and `fq_count` staying 0.
  - Without the macro, the same pair appears one cycle later.
